// File: rtl/univ_shift_reg_seq.sv
// univ_shift_reg_seq
// Universal shift register with a multi-step sequencer. One accepted start
// command performs 0..2^CNT_W-1 one-bit steps (one per clock) of the chosen
// operation and finishes with a one-cycle done pulse.
//
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   start   command strobe, accepted only while idle
//   mode    operation (sampled on accept):
//           000 HOLD, 001 SHR, 010 SHL, 011 LOAD, 100 ROR, 101 ROL,
//           110 ASR, 111 reserved (HOLD)
//   amount  number of one-bit steps (sampled on accept)
//   din     parallel load data
//   sl      serial input for SHL (fills LSB), sampled live at every step
//   sr      serial input for SHR (fills MSB), sampled live at every step
//   q       register contents
//   busy    multi-step command in progress
//   done    one-cycle completion pulse
//   cout    (only with USRS_CARRY_EN) bit shifted/rotated out by the last step
//
// Optional feature macro: USRS_CARRY_EN adds the registered cout output.
module univ_shift_reg_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [CNT_W-1:0] amount,
  input  logic [WIDTH-1:0] din,
  input  logic             sl,
  input  logic             sr,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
`ifdef USRS_CARRY_EN
  ,
  output logic             cout
`endif
);

  localparam logic [2:0] M_SHR  = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_LOAD = 3'b011;
  localparam logic [2:0] M_ROR  = 3'b100;
  localparam logic [2:0] M_ROL  = 3'b101;
  localparam logic [2:0] M_ASR  = 3'b110;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg,   cnt_next;
  logic [2:0]       mode_reg,  mode_next;
  logic [WIDTH-1:0] q_reg,     q_next;
  logic             done_reg,  done_next;

  // One-step results of every operation, built bit by bit.
  logic [WIDTH-1:0] shr_v, shl_v, ror_v, rol_v, asr_v;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_step
      if (gi == WIDTH-1) begin : g_msb
        assign shr_v[gi] = sr;
        assign ror_v[gi] = q_reg[0];
        assign asr_v[gi] = q_reg[WIDTH-1];
      end else begin : g_low
        assign shr_v[gi] = q_reg[gi+1];
        assign ror_v[gi] = q_reg[gi+1];
        assign asr_v[gi] = q_reg[gi+1];
      end
      if (gi == 0) begin : g_lsb
        assign shl_v[gi] = sl;
        assign rol_v[gi] = q_reg[WIDTH-1];
      end else begin : g_high
        assign shl_v[gi] = q_reg[gi-1];
        assign rol_v[gi] = q_reg[gi-1];
      end
    end
  endgenerate

  // While idle the step uses the incoming mode (first step happens on the
  // accept edge); during RUN it uses the mode latched at accept.
  logic [2:0]       step_mode;
  logic [WIDTH-1:0] step_q;
  logic             is_shift;

  assign step_mode = (state_reg == IDLE) ? mode : mode_reg;

  always_comb begin
    step_q = q_reg;
    case (step_mode)
      M_SHR:   step_q = shr_v;
      M_SHL:   step_q = shl_v;
      M_ROR:   step_q = ror_v;
      M_ROL:   step_q = rol_v;
      M_ASR:   step_q = asr_v;
      default: step_q = q_reg;
    endcase
  end

  always_comb begin
    case (mode)
      M_SHR, M_SHL, M_ROR, M_ROL, M_ASR: is_shift = 1'b1;
      default:                           is_shift = 1'b0;
    endcase
  end

`ifdef USRS_CARRY_EN
  logic cout_reg, cout_next, step_c;

  // Right-moving ops expose the old LSB, left-moving ops the old MSB.
  always_comb begin
    step_c = cout_reg;
    case (step_mode)
      M_SHR, M_ROR, M_ASR: step_c = q_reg[0];
      M_SHL, M_ROL:        step_c = q_reg[WIDTH-1];
      default:             step_c = cout_reg;
    endcase
  end
`endif

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    mode_next  = mode_reg;
    q_next     = q_reg;
    done_next  = 1'b0;
`ifdef USRS_CARRY_EN
    cout_next  = cout_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (start) begin
          mode_next = mode;
          if (mode == M_LOAD) begin
            q_next    = din;
            done_next = 1'b1;
`ifdef USRS_CARRY_EN
            cout_next = 1'b0;
`endif
          end else if (is_shift && (amount != '0)) begin
            q_next = step_q;
`ifdef USRS_CARRY_EN
            cout_next = step_c;
`endif
            if (amount == CNT_W'(1)) begin
              done_next = 1'b1;
            end else begin
              state_next = RUN;
              cnt_next   = amount - CNT_W'(1);
            end
          end else begin
            // HOLD, reserved, or zero-length shift: complete immediately.
            done_next = 1'b1;
          end
        end
      end
      RUN: begin
        q_next   = step_q;
        cnt_next = cnt_reg - CNT_W'(1);
`ifdef USRS_CARRY_EN
        cout_next = step_c;
`endif
        if (cnt_reg == CNT_W'(1)) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      mode_reg  <= '0;
      q_reg     <= '0;
      done_reg  <= 1'b0;
`ifdef USRS_CARRY_EN
      cout_reg  <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      mode_reg  <= mode_next;
      q_reg     <= q_next;
      done_reg  <= done_next;
`ifdef USRS_CARRY_EN
      cout_reg  <= cout_next;
`endif
    end
  end

  assign q    = q_reg;
  assign busy = (state_reg == RUN);
  assign done = done_reg;
`ifdef USRS_CARRY_EN
  assign cout = cout_reg;
`endif

endmodule

// File: tb/tb_univ_shift_reg_seq.sv
// Directed, table-driven bench for univ_shift_reg_seq (WIDTH=8, CNT_W=4).
module tb_univ_shift_reg_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [2:0] mode = 3'b000;
  logic [3:0] amount = 4'd0;
  logic [7:0] din = 8'h00;
  logic       sl = 1'b0;
  logic       sr = 1'b0;
  logic [7:0] q;
  logic       busy;
  logic       done;
`ifdef USRS_CARRY_EN
  logic       cout;
`endif

  int total = 0;
  int bad   = 0;

  univ_shift_reg_seq #(.WIDTH(8), .CNT_W(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .mode   (mode),
    .amount (amount),
    .din    (din),
    .sl     (sl),
    .sr     (sr),
    .q      (q),
    .busy   (busy),
    .done   (done)
`ifdef USRS_CARRY_EN
    ,
    .cout   (cout)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] mode;
    logic [3:0] amount;
    logic [7:0] din;
    logic       sl;
    logic       sr;
    logic [7:0] exp_q;
    int         exp_busy;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Issue one command, then wait (bounded) for done while counting busy cycles.
  task automatic run_cmd(input logic [2:0] m, input logic [3:0] a, input logic [7:0] d,
                         input logic l, input logic r,
                         output logic [7:0] q_o, output int bcnt, output bit got);
    @(negedge clk);
    start = 1'b1; mode = m; amount = a; din = d; sl = l; sr = r;
    @(negedge clk);
    start = 1'b0;
    bcnt = 0;
    got  = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      if (busy) bcnt++;
      @(negedge clk);
    end
    q_o = q;
  endtask

  logic [7:0] qr;
  int         bc;
  bit         gd;
  int         seen;

  initial begin
    //           mode    amt    din    sl    sr    exp_q  busy
    vecs[0]  = '{3'b011, 4'd0,  8'h3A, 1'b0, 1'b0, 8'h3A, 0};  // LOAD
    vecs[1]  = '{3'b001, 4'd3,  8'h00, 1'b0, 1'b1, 8'hE7, 2};  // SHR x3, sr=1
    vecs[2]  = '{3'b011, 4'd0,  8'h3A, 1'b0, 1'b0, 8'h3A, 0};  // LOAD
    vecs[3]  = '{3'b101, 4'd4,  8'h00, 1'b0, 1'b0, 8'hA3, 3};  // ROL x4
    vecs[4]  = '{3'b110, 4'd2,  8'h00, 1'b0, 1'b0, 8'hE8, 1};  // ASR x2
    vecs[5]  = '{3'b000, 4'd5,  8'hFF, 1'b1, 1'b1, 8'hE8, 0};  // HOLD
    vecs[6]  = '{3'b111, 4'd3,  8'hFF, 1'b1, 1'b1, 8'hE8, 0};  // reserved
    vecs[7]  = '{3'b100, 4'd1,  8'h00, 1'b0, 1'b0, 8'h74, 0};  // ROR x1
    vecs[8]  = '{3'b010, 4'd0,  8'h00, 1'b1, 1'b1, 8'h74, 0};  // SHL x0
    vecs[9]  = '{3'b011, 4'd9,  8'h81, 1'b0, 1'b0, 8'h81, 0};  // LOAD ignores amount
    vecs[10] = '{3'b100, 4'd9,  8'h00, 1'b0, 1'b0, 8'hC0, 8};  // ROR x9 wraps
    vecs[11] = '{3'b010, 4'd15, 8'h00, 1'b1, 1'b0, 8'hFF, 14}; // SHL x15, sl=1
    vecs[12] = '{3'b110, 4'd3,  8'h00, 1'b0, 1'b0, 8'hFF, 2};  // ASR keeps sign
    vecs[13] = '{3'b001, 4'd15, 8'h00, 1'b0, 1'b0, 8'h00, 14}; // SHR x15, sr=0
    vecs[14] = '{3'b011, 4'd0,  8'h3A, 1'b0, 1'b0, 8'h3A, 0};  // LOAD
    vecs[15] = '{3'b010, 4'd0,  8'h00, 1'b1, 1'b1, 8'h3A, 0};  // SHL x0 unchanged

    // Asynchronous reset mid-cycle, checked before any clock edge.
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_q", q, 8'h00);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
`ifdef USRS_CARRY_EN
    chk("reset_cout", cout, 1'b0);
`endif
    $display("txn reset: q=%0h busy=%0b done=%0b", q, busy, done);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven commands.
    for (int i = 0; i < 16; i++) begin
      run_cmd(vecs[i].mode, vecs[i].amount, vecs[i].din, vecs[i].sl, vecs[i].sr, qr, bc, gd);
      chk($sformatf("v%0d_done", i), gd, 1'b1);
      chk($sformatf("v%0d_q", i), qr, vecs[i].exp_q);
      chk($sformatf("v%0d_busy", i), bc, vecs[i].exp_busy);
      @(negedge clk);
      chk($sformatf("v%0d_done1cyc", i), done, 1'b0);
      $display("txn v%0d: mode=%0b amt=%0d q=%0h busy_cycles=%0d", i,
               vecs[i].mode, vecs[i].amount, qr, bc);
    end

    // SHR step by step from 0x3A with sr=1.
    run_cmd(3'b011, 4'd0, 8'h3A, 1'b0, 1'b0, qr, bc, gd);
    @(negedge clk);
    start = 1'b1; mode = 3'b001; amount = 4'd3; sr = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("shr_s1_q", q, 8'h9D); chk("shr_s1_busy", busy, 1'b1); chk("shr_s1_done", done, 1'b0);
`ifdef USRS_CARRY_EN
    chk("shr_s1_cout", cout, 1'b0);
`endif
    @(negedge clk);
    chk("shr_s2_q", q, 8'hCE); chk("shr_s2_busy", busy, 1'b1); chk("shr_s2_done", done, 1'b0);
`ifdef USRS_CARRY_EN
    chk("shr_s2_cout", cout, 1'b1);
`endif
    @(negedge clk);
    chk("shr_s3_q", q, 8'hE7); chk("shr_s3_busy", busy, 1'b0); chk("shr_s3_done", done, 1'b1);
`ifdef USRS_CARRY_EN
    chk("shr_s3_cout", cout, 1'b0);
`endif
    $display("txn shr_steps: q=%0h", q);

    // ROL x4 then back-to-back ASR x2 issued while done is high.
    run_cmd(3'b011, 4'd0, 8'h3A, 1'b0, 1'b0, qr, bc, gd);
    run_cmd(3'b101, 4'd4, 8'h00, 1'b0, 1'b0, qr, bc, gd);
    chk("b2b_rol_q", qr, 8'hA3);
    chk("b2b_rol_done", gd, 1'b1);
    start = 1'b1; mode = 3'b110; amount = 4'd2;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_asr1_q", q, 8'hD1);
    chk("b2b_asr1_busy", busy, 1'b1);
    @(negedge clk);
    chk("b2b_asr2_q", q, 8'hE8);
    chk("b2b_asr2_done", done, 1'b1);
    $display("txn back_to_back: q=%0h", q);

    // start while busy is ignored.
    run_cmd(3'b011, 4'd0, 8'h01, 1'b0, 1'b0, qr, bc, gd);
    @(negedge clk);
    start = 1'b1; mode = 3'b010; amount = 4'd5; sl = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; mode = 3'b011; din = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    gd = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (done) begin
        gd = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("ignore_done", gd, 1'b1);
    chk("ignore_q", q, 8'h20);
    $display("txn ignore_start: q=%0h", q);

    // Reset in the middle of a long SHR: everything clears, no done follows.
    run_cmd(3'b011, 4'd0, 8'hC3, 1'b0, 1'b0, qr, bc, gd);
    @(negedge clk);
    start = 1'b1; mode = 3'b001; amount = 4'd7; sr = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("midrst_pre_busy", busy, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_q", q, 8'h00);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    #1 rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    chk("midrst_no_done", seen, 0);
    chk("midrst_q_after", q, 8'h00);
    $display("txn reset_mid_run: q=%0h", q);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
